// File: rtl/ws2812_pkg.sv
// Shared command codes, FSM state encoding and pixel type
// for the WS2812 strip sequencer.
package ws2812_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_SEND  = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SEND  = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/ws2812_pixel_buffer.sv
// Pixel colour store: one write port, one combinational
// read port, cleared by reset.
module ws2812_pixel_buffer #(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_PIXELS);

  logic [23:0] mem [NUM_PIXELS];
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH);
  assign rd_ok = {1'b0, rd_addr} < DEPTH;

  // Store in-range writes; out-of-range addresses are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem[rd_addr] : '0;

endmodule

// File: rtl/ws2812_strip_sequencer.sv
// Walks the pixel buffer and feeds SEND / RESET commands
// with colour data to a WS2812 rgb controller.
module ws2812_strip_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              start,
  input  logic              continuous,
  output logic [1:0]        ctrl_cmd,
  output logic [7:0]        ctrl_r,
  output logic [7:0]        ctrl_g,
  output logic [7:0]        ctrl_b,
  input  logic              ctrl_cmd_req,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_PIXELS);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  rgb_t              pix;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [ADDR_W:0]   len_cap;
  logic              last;

  // In SEND the next pixel is prefetched; otherwise pixel 0
  assign rd_addr = (state == ST_SEND) ? idx + 1'b1 : '0;

  assign len_cap = (frame_len > DEPTH) ? DEPTH : frame_len;
  assign last    = ({1'b0, idx} == len - 1'b1);

  ws2812_pixel_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Frame sequencing FSM with registered controller outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      len      <= '0;
      pix      <= '0;
      ctrl_cmd <= CMD_NOP;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len  <= len_cap;
            idx  <= '0;
            busy <= 1'b1;
            if (frame_len != '0) begin
              state    <= ST_SEND;
              ctrl_cmd <= CMD_SEND;
              pix      <= rgb_t'(rd_data);
            end else begin
              state    <= ST_LATCH;
              ctrl_cmd <= CMD_RESET;
            end
          end
        end
        ST_SEND: begin
          if (ctrl_cmd_req) begin
            if (last) begin
              state    <= ST_LATCH;
              ctrl_cmd <= CMD_RESET;
            end else begin
              idx <= idx + 1'b1;
              pix <= rgb_t'(rd_data);
            end
          end
        end
        ST_LATCH: begin
          if (ctrl_cmd_req) begin
            done <= 1'b1;
            if (continuous && len != '0) begin
              state    <= ST_SEND;
              ctrl_cmd <= CMD_SEND;
              idx      <= '0;
              pix      <= rgb_t'(rd_data);
            end else if (continuous) begin
              ctrl_cmd <= CMD_RESET;
            end else begin
              state    <= ST_IDLE;
              ctrl_cmd <= CMD_NOP;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          ctrl_cmd <= CMD_NOP;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_r = pix.r;
  assign ctrl_g = pix.g;
  assign ctrl_b = pix.b;

endmodule
